prach_deframer: RTL and testbench

PRACH_DEFRAMER -- requirements
Module: prach_deframer

---
 rtl/prach_deframer.sv | 172 +++++++++++++++++
 tb/tb_prach_deframer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prach_deframer.sv
// PRACH deframer: unpacks 4-sample Avalon-ST beats into per-sample I/Q with packet framing checks.
// Optional statistics counters are built only when PRACH_DEFRAMER_STATS_EN is defined.
module prach_deframer #(
    parameter int PKT_BEATS = 216
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] avst_sink_data,
    input  logic         avst_sink_valid,
    input  logic [15:0]  avst_sink_channel,
    input  logic         avst_sink_startofpacket,
    input  logic         avst_sink_endofpacket,
    output logic         avst_sink_ready,
    output logic [15:0]  dout_dr,
    output logic [15:0]  dout_di,
    output logic         dout_dv,
    output logic         dout_sop,
    output logic         dout_eop,
    output logic [15:0]  dout_chn,
    output logic         err_pulse,
    output logic [15:0]  stat_pkt_cnt,
    output logic [15:0]  stat_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DROP
    } state_t;

    localparam logic [11:0] LP_LAST = 12'(PKT_BEATS);

    state_t        r_state;
    logic [11:0]   r_beats;
    logic [127:0]  r_hold;
    logic          r_full;
    logic [1:0]    r_idx;
    logic          r_bsop;
    logic          r_beop;
    logic [15:0]   r_chn;
    logic          r_err;

    logic          w_acc;
    logic          w_load;
    logic          w_lsop;
    logic          w_leop;
    logic          w_err;
    state_t        w_nstate;
    logic [11:0]   w_nbeats;
    logic [11:0]   w_beat_nxt;
    logic [31:0]   w_smp;

    // A new beat may land on the same edge the last held sample leaves
    assign avst_sink_ready = !rst && (!r_full || (r_idx == 2'd3));
    assign w_acc           = avst_sink_valid && avst_sink_ready;
    assign w_beat_nxt      = r_beats + 12'd1;

    always_comb begin
        w_load   = 1'b0;
        w_lsop   = 1'b0;
        w_leop   = 1'b0;
        w_err    = 1'b0;
        w_nstate = r_state;
        w_nbeats = r_beats;
        if (w_acc) begin
            if (avst_sink_startofpacket) begin
                // SOP always opens a packet; inside BODY it aborts the old one
                w_load   = 1'b1;
                w_lsop   = 1'b1;
                w_nbeats = 12'd1;
                w_err    = (r_state == S_BODY);
                if (avst_sink_endofpacket) begin
                    w_err    = 1'b1;
                    w_nstate = S_IDLE;
                end else begin
                    w_nstate = S_BODY;
                end
            end else begin
                unique case (r_state)
                    S_IDLE: w_err = 1'b1;
                    S_BODY: begin
                        w_load   = 1'b1;
                        w_nbeats = w_beat_nxt;
                        if (w_beat_nxt == LP_LAST) begin
                            w_leop   = 1'b1;
                            w_err    = !avst_sink_endofpacket;
                            w_nstate = avst_sink_endofpacket ? S_IDLE : S_DROP;
                        end else if (avst_sink_endofpacket) begin
                            w_err    = 1'b1;
                            w_nstate = S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_hold  <= '0;
            r_full  <= 1'b0;
            r_idx   <= '0;
            r_bsop  <= 1'b0;
            r_beop  <= 1'b0;
            r_chn   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_beats <= w_nbeats;
            r_err   <= w_err;
            if (w_load) begin
                r_hold <= avst_sink_data;
                r_full <= 1'b1;
                r_idx  <= '0;
                r_bsop <= w_lsop;
                r_beop <= w_leop;
                if (w_lsop) begin
                    r_chn <= avst_sink_channel;
                end
            end else if (r_full) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_full <= 1'b0;
                end
            end
        end
    end

    assign w_smp     = r_hold[{r_idx, 5'd0} +: 32];
    assign dout_dr   = r_full ? w_smp[31:16] : 16'd0;
    assign dout_di   = r_full ? w_smp[15:0] : 16'd0;
    assign dout_dv   = r_full;
    assign dout_sop  = r_full && r_bsop && (r_idx == 2'd0);
    assign dout_eop  = r_full && r_beop && (r_idx == 2'd3);
    assign dout_chn  = r_chn;
    assign err_pulse = r_err;

`ifdef PRACH_DEFRAMER_STATS_EN
    logic        w_good;
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_err_cnt;

    assign w_good = w_acc && (r_state == S_BODY)
                 && !avst_sink_startofpacket
                 && avst_sink_endofpacket
                 && (w_beat_nxt == LP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_good) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_err) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt = r_pkt_cnt;
    assign stat_err_cnt = r_err_cnt;
`else
    assign stat_pkt_cnt = 16'd0;
    assign stat_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prach_deframer.sv
// Scoreboard bench for prach_deframer with PKT_BEATS=4.
// Driver pushes expected samples; a parallel monitor pops and compares on dout_dv.
module tb_prach_deframer;

    localparam int PB = 4;

    typedef struct packed {
        logic [15:0] dr;
        logic [15:0] di;
        logic        sop;
        logic        eop;
        logic [15:0] chn;
    } smp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] avst_sink_data = '0;
    logic         avst_sink_valid = 1'b0;
    logic [15:0]  avst_sink_channel = '0;
    logic         avst_sink_startofpacket = 1'b0;
    logic         avst_sink_endofpacket = 1'b0;
    logic         avst_sink_ready;
    logic [15:0]  dout_dr;
    logic [15:0]  dout_di;
    logic         dout_dv;
    logic         dout_sop;
    logic         dout_eop;
    logic [15:0]  dout_chn;
    logic         err_pulse;
    logic [15:0]  stat_pkt_cnt;
    logic [15:0]  stat_err_cnt;

    smp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   exp_pkt = 0;

    prach_deframer #(.PKT_BEATS(PB)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .avst_sink_data          (avst_sink_data),
        .avst_sink_valid         (avst_sink_valid),
        .avst_sink_channel       (avst_sink_channel),
        .avst_sink_startofpacket (avst_sink_startofpacket),
        .avst_sink_endofpacket   (avst_sink_endofpacket),
        .avst_sink_ready         (avst_sink_ready),
        .dout_dr                 (dout_dr),
        .dout_di                 (dout_di),
        .dout_dv                 (dout_dv),
        .dout_sop                (dout_sop),
        .dout_eop                (dout_eop),
        .dout_chn                (dout_chn),
        .err_pulse               (err_pulse),
        .stat_pkt_cnt            (stat_pkt_cnt),
        .stat_err_cnt            (stat_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int stat_exp(input int v);
`ifdef PRACH_DEFRAMER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample j of a beat carries I=base+j+1, Q=base+j
    task automatic send(input int base, input logic s, input logic e,
                        input logic [15:0] ch, input bit emit,
                        input bit msop, input bit meop, input logic [15:0] ech);
        logic [127:0] d;
        smp_t         x;
        int           n;
        for (int j = 0; j < 4; j++) begin
            d[32*j +: 32] = {16'(base + j + 1), 16'(base + j)};
        end
        @(negedge clk);
        avst_sink_data          = d;
        avst_sink_valid         = 1'b1;
        avst_sink_channel       = ch;
        avst_sink_startofpacket = s;
        avst_sink_endofpacket   = e;
        n = 0;
        while (!avst_sink_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end else if (emit) begin
            for (int j = 0; j < 4; j++) begin
                x.dr  = 16'(base + j + 1);
                x.di  = 16'(base + j);
                x.sop = msop && (j == 0);
                x.eop = meop && (j == 3);
                x.chn = ech;
                q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        avst_sink_valid         = 1'b0;
        avst_sink_startofpacket = 1'b0;
        avst_sink_endofpacket   = 1'b0;
    endtask

    task automatic cp(input string name);
        repeat (8) @(negedge clk);
        chk({name, "_q_empty"}, q.size(), 0);
        chk({name, "_err_pulses"}, err_seen, exp_err);
        chk({name, "_pkt_cnt"}, stat_pkt_cnt, stat_exp(exp_pkt));
        chk({name, "_err_cnt"}, stat_err_cnt, stat_exp(exp_err));
    endtask

    initial begin
        fork
            begin : mon
                smp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (err_pulse) err_seen++;
                        if (dout_dv) begin
                            checks++;
                            if (q.size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_dv: got dr=%0h di=%0h expected no sample",
                                         dout_dr, dout_di);
                            end else begin
                                e = q.pop_front();
                                if ({dout_dr, dout_di, dout_sop, dout_eop, dout_chn} !== e) begin
                                    errors++;
                                    $display("FAIL sample: got dr=%0h di=%0h sop=%0b eop=%0b chn=%0h expected dr=%0h di=%0h sop=%0b eop=%0b chn=%0h",
                                             dout_dr, dout_di, dout_sop, dout_eop, dout_chn,
                                             e.dr, e.di, e.sop, e.eop, e.chn);
                                end
                            end
                        end
                    end
                end
            end
            begin : drv
                repeat (3) @(negedge clk);
                chk("rst_ready", avst_sink_ready, 0);
                chk("rst_dv", dout_dv, 0);
                chk("rst_dr", dout_dr, 0);
                chk("rst_err", err_pulse, 0);
                chk("rst_pkt", stat_pkt_cnt, 0);
                rst = 1'b0;
                @(negedge clk);
                chk("rel_ready", avst_sink_ready, 1);

                // good packet, first beat is the canonical bit-exact pattern
                send(0, 1, 0, 16'h5, 1, 1, 0, 16'h5);
                send(4, 0, 0, 16'h5, 1, 0, 0, 16'h5);
                send(8, 0, 0, 16'h5, 1, 0, 0, 16'h5);
                send(12, 0, 1, 16'h5, 1, 0, 1, 16'h5);
                exp_pkt = 1;
                cp("good");

                send(100, 0, 0, 16'h7, 0, 0, 0, 16'h7);
                exp_err = 1;
                cp("nosop");

                send(200, 1, 0, 16'h9, 1, 1, 0, 16'h9);
                send(204, 0, 1, 16'h9, 1, 0, 0, 16'h9);
                exp_err = 2;
                cp("early_eop");

                send(300, 1, 0, 16'h3, 1, 1, 0, 16'h3);
                send(304, 0, 0, 16'h3, 1, 0, 0, 16'h3);
                send(308, 0, 0, 16'h3, 1, 0, 0, 16'h3);
                send(312, 0, 0, 16'h3, 1, 0, 1, 16'h3);
                send(316, 0, 0, 16'h3, 0, 0, 0, 16'h3);
                send(320, 0, 1, 16'h3, 0, 0, 0, 16'h3);
                send(400, 1, 0, 16'h4, 1, 1, 0, 16'h4);
                send(404, 0, 0, 16'h4, 1, 0, 0, 16'h4);
                send(408, 0, 0, 16'h4, 1, 0, 0, 16'h4);
                send(412, 0, 1, 16'h4, 1, 0, 1, 16'h4);
                exp_err = 3;
                exp_pkt = 2;
                cp("missing_eop");

                send(500, 1, 0, 16'h6, 1, 1, 0, 16'h6);
                send(504, 1, 0, 16'h8, 1, 1, 0, 16'h8);
                send(508, 0, 0, 16'h8, 1, 0, 0, 16'h8);
                send(512, 0, 0, 16'h8, 1, 0, 0, 16'h8);
                send(516, 0, 1, 16'h8, 1, 0, 1, 16'h8);
                exp_err = 4;
                exp_pkt = 3;
                cp("mid_sop");

                send(600, 1, 0, 16'h2, 1, 1, 0, 16'h2);
                send(604, 0, 0, 16'h2, 1, 0, 0, 16'h2);
                repeat (6) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_dv", dout_dv, 0);
                chk("mid_rst_eop", dout_eop, 0);
                chk("mid_rst_chn", dout_chn, 0);
                chk("mid_rst_err", err_pulse, 0);
                chk("mid_rst_cnt", stat_err_cnt, 0);
                q.delete();
                err_seen = 0;
                exp_err = 0;
                exp_pkt = 0;
                rst = 1'b0;
                send(700, 1, 0, 16'h1, 1, 1, 0, 16'h1);
                send(704, 0, 0, 16'h1, 1, 0, 0, 16'h1);
                send(708, 0, 0, 16'h1, 1, 0, 0, 16'h1);
                send(712, 0, 1, 16'h1, 1, 0, 1, 16'h1);
                exp_pkt = 1;
                cp("after_rst");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
